// File: rtl/entropy_vlc_pkg.sv
// Shared codebook table, codebook field helpers and the CODE_W width check
// used by the ProRes VLC coders (AC level, AC run, DC).
`ifndef ENTROPY_VLC_PKG_SV
`define ENTROPY_VLC_PKG_SV

`define ENTROPY_VLC_CHECK_CODE_W(code_w, coeff_w) \
    if ((code_w) < 2 * (coeff_w) + 2) begin : g_code_w_check \
        $error("entropy_vlc: CODE_W must be at least 2*COEFF_W+2"); \
    end

package entropy_vlc_pkg;

    localparam int unsigned CB_W    = 8;
    localparam int unsigned LEV_W   = 4;
    localparam int unsigned LEV_MAX = 9;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][CB_W-1:0] LEV_TO_CB = {
        8'h4C, 8'h28, 8'h28, 8'h28, 8'h28,
        8'h04, 8'h06, 8'h05, 8'h0A, 8'h04
    };

    function automatic logic [CB_W-1:0] lev_to_cb(input logic [LEV_W-1:0] lev);
        return (lev > LEV_W'(LEV_MAX)) ? LEV_TO_CB[LEV_MAX] : LEV_TO_CB[lev];
    endfunction

    function automatic logic [1:0] cb_switch(input logic [CB_W-1:0] cb);
        return 2'(cb);
    endfunction

    function automatic logic [2:0] cb_exp_k(input logic [CB_W-1:0] cb);
        return 3'(cb >> 2);
    endfunction

    function automatic logic [2:0] cb_rice_k(input logic [CB_W-1:0] cb);
        return 3'(cb >> 5);
    endfunction

endpackage

`endif

// File: rtl/entropy_vlc_codeword.sv
// Unified Rice / Exp-Golomb codeword generator: stage 2 picks the path and the
// exponent, stage 3 assembles the right-aligned {code, sign} and its length.
module entropy_vlc_codeword
    import entropy_vlc_pkg::*;
#(
    parameter int unsigned VAL_W  = 20,
    parameter int unsigned CODE_W = 48,
    parameter int unsigned LEN_W  = $clog2(CODE_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [VAL_W-1:0]  i_val,
    input  logic [CB_W-1:0]   i_cb,
    input  logic              i_sign,
    input  logic              i_nul,
    input  logic              i_sop,
    input  logic              i_eop,
    output logic              o_valid,
    output logic [CODE_W-1:0] o_code,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_sop,
    output logic              o_eop
);
    // Headroom for the (switch+1)<<rice_k and 1<<exp_k offsets.
    localparam int unsigned T_W = VAL_W + 8;
    localparam int unsigned E_W = $clog2(T_W);

    logic [T_W-1:0] w_val_x;
    logic [T_W-1:0] w_thr;
    logic [T_W-1:0] w_t;
    logic           w_rice;
    logic [E_W-1:0] w_e;

    logic             r_s2_valid;
    logic             r_s2_rice;
    logic [T_W-1:0]   r_s2_t;
    logic [E_W-1:0]   r_s2_e;
    logic [VAL_W-1:0] r_s2_val;
    logic [CB_W-1:0]  r_s2_cb;
    logic             r_s2_sign;
    logic             r_s2_nul;
    logic             r_s2_sop;
    logic             r_s2_eop;

    assign w_val_x = T_W'(i_val);
    assign w_thr   = (T_W'(cb_switch(i_cb)) + T_W'(1)) << cb_rice_k(i_cb);
    assign w_rice  = w_val_x < w_thr;
    assign w_t     = w_val_x - w_thr + (T_W'(1) << cb_exp_k(i_cb));

    // floor(log2(t)): position of the highest set bit.
    always_comb begin
        w_e = '0;
        for (int i = 0; i < int'(T_W); i++) begin
            if (w_t[i]) w_e = E_W'(i);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_rice  <= 1'b0;
            r_s2_t     <= '0;
            r_s2_e     <= '0;
            r_s2_val   <= '0;
            r_s2_cb    <= '0;
            r_s2_sign  <= 1'b0;
            r_s2_nul   <= 1'b0;
            r_s2_sop   <= 1'b0;
            r_s2_eop   <= 1'b0;
        end else if (i_en) begin
            r_s2_valid <= i_valid;
            r_s2_rice  <= w_rice;
            r_s2_t     <= w_t;
            r_s2_e     <= w_e;
            r_s2_val   <= i_val;
            r_s2_cb    <= i_cb;
            r_s2_sign  <= i_sign;
            r_s2_nul   <= i_nul;
            r_s2_sop   <= i_sop;
            r_s2_eop   <= i_eop;
        end
    end

    logic [1:0]       w_sw;
    logic [2:0]       w_ek;
    logic [2:0]       w_rk;
    logic [T_W-1:0]   w_rice_val;
    logic [LEN_W-1:0] w_rice_len;
    logic [LEN_W-1:0] w_exp_len;

    assign w_sw = cb_switch(r_s2_cb);
    assign w_ek = cb_exp_k(r_s2_cb);
    assign w_rk = cb_rice_k(r_s2_cb);

    // Leading zeros carry no value, so only the terminating '1' and tail matter.
    assign w_rice_val = (T_W'(1) << w_rk) | (T_W'(r_s2_val) & ((T_W'(1) << w_rk) - T_W'(1)));
    assign w_rice_len = LEN_W'(r_s2_val >> w_rk) + LEN_W'(w_rk) + LEN_W'(2);
    assign w_exp_len  = LEN_W'(r_s2_e) + LEN_W'(r_s2_e) + LEN_W'(w_sw) + LEN_W'(2) - LEN_W'(w_ek);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_valid <= 1'b0;
            o_code  <= '0;
            o_len   <= '0;
            o_sop   <= 1'b0;
            o_eop   <= 1'b0;
        end else if (i_en) begin
            o_valid <= r_s2_valid;
            o_sop   <= r_s2_sop;
            o_eop   <= r_s2_eop;
            if (r_s2_nul) begin
                o_code <= '0;
                o_len  <= '0;
            end else begin
                o_code <= CODE_W'({(r_s2_rice ? w_rice_val : r_s2_t), r_s2_sign});
                o_len  <= r_s2_rice ? w_rice_len : w_exp_len;
            end
        end
    end

endmodule

// File: rtl/entropy_ac_level_vlc.sv
// ProRes AC-level entropy coder: adaptive-codebook VLC of |level|-1 plus sign.
// Optional per-slice bit count on slice_bits when AC_LEVEL_STATS_EN is defined.
module entropy_ac_level_vlc
    import entropy_vlc_pkg::*;
#(
    parameter int unsigned COEFF_W = 20,
    parameter int unsigned CODE_W  = 48,
    parameter int unsigned LEN_W   = $clog2(CODE_W + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    input  logic               in_sop,
    input  logic               in_eop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CODE_W-1:0]  out_code,
    output logic [LEN_W-1:0]   out_len,
    output logic               out_sop,
    output logic               out_eop
`ifdef AC_LEVEL_STATS_EN
    ,
    output logic [31:0]        slice_bits
`endif
);
    localparam int unsigned ABS_W = COEFF_W + 1;

    `ENTROPY_VLC_CHECK_CODE_W(CODE_W, COEFF_W)

    logic               w_advance;
    logic               w_accept;
    logic               w_sign;
    logic               w_nonzero;
    logic [ABS_W-1:0]   w_ext;
    logic [ABS_W-1:0]   w_abs;
    logic [COEFF_W-1:0] w_val;
    logic [LEV_W-1:0]   w_lev;
    logic [LEV_W-1:0]   w_prev_use;

    logic               r_s1_valid;
    logic [COEFF_W-1:0] r_s1_val;
    logic [CB_W-1:0]    r_s1_cb;
    logic               r_s1_sign;
    logic               r_s1_nul;
    logic               r_s1_sop;
    logic               r_s1_eop;
    logic [LEV_W-1:0]   r_prev;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_accept  = in_valid && w_advance;

    // Absolute value at COEFF_W+1 bits so the most-negative input is exact.
    assign w_sign     = in_coeff[COEFF_W-1];
    assign w_nonzero  = |in_coeff;
    assign w_ext      = {w_sign, in_coeff};
    assign w_abs      = w_sign ? (~w_ext + ABS_W'(1)) : w_ext;
    assign w_val      = COEFF_W'(w_abs - ABS_W'(1));
    assign w_lev      = (w_abs > ABS_W'(LEV_MAX)) ? LEV_W'(LEV_MAX) : LEV_W'(w_abs);
    assign w_prev_use = in_sop ? LEV_W'(1) : r_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_val   <= '0;
            r_s1_cb    <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_nul   <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= w_accept && (w_nonzero || in_sop || in_eop);
            r_s1_val   <= w_val;
            r_s1_cb    <= lev_to_cb(w_prev_use);
            r_s1_sign  <= w_sign;
            r_s1_nul   <= !w_nonzero;
            r_s1_sop   <= in_sop;
            r_s1_eop   <= in_eop;
        end
    end

    // Codebook context: zeros leave it alone, a zero sop still restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= LEV_W'(1);
        end else if (w_accept) begin
            if (w_nonzero) r_prev <= w_lev;
            else if (in_sop) r_prev <= LEV_W'(1);
        end
    end

    entropy_vlc_codeword #(
        .VAL_W  (COEFF_W),
        .CODE_W (CODE_W),
        .LEN_W  (LEN_W)
    ) u_codeword (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_advance),
        .i_valid (r_s1_valid),
        .i_val   (r_s1_val),
        .i_cb    (r_s1_cb),
        .i_sign  (r_s1_sign),
        .i_nul   (r_s1_nul),
        .i_sop   (r_s1_sop),
        .i_eop   (r_s1_eop),
        .o_valid (out_valid),
        .o_code  (out_code),
        .o_len   (out_len),
        .o_sop   (out_sop),
        .o_eop   (out_eop)
    );

`ifdef AC_LEVEL_STATS_EN
    logic [31:0] r_acc;
    logic [32:0] w_sum;
    logic [31:0] w_acc_next;

    assign w_sum      = {1'b0, r_acc} + 33'(out_len);
    assign w_acc_next = out_sop ? 32'(out_len) : (w_sum[32] ? '1 : w_sum[31:0]);

    // Saturating per-slice bit count, published on the eop beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc      <= '0;
            slice_bits <= '0;
        end else if (out_valid && out_ready) begin
            r_acc <= w_acc_next;
            if (out_eop) slice_bits <= w_acc_next;
        end
    end
`endif

endmodule

// File: doc/entropy_ac_level_vlc.md
# entropy_ac_level_vlc

Parametrised ProRes AC-level entropy coder: takes one signed quantised AC coefficient per beat in scan order, skips zeros, and emits the adaptive-codebook VLC for abs(level)-1 plus a trailing sign bit as a right-aligned code/length pair. Sits between the scan/run splitter and the slice bit packer, in parallel with the run coder. Generalises the fixed-32-bit level coder: it adds width parameters, full valid/ready backpressure, a single unified Rice/Exp-Golomb codeword generator, and per-slice codebook adaptation reset.

## Interface
- COEFF_W, 20: signed coefficient width.
- CODE_W, 48: output code width; must be ≥ 2*COEFF_W+2 (elaboration error otherwise).
- LEN_W, $clog2(CODE_W+1): length field width.
- clk  in  1  clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  coefficient beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- in_coeff  in  COEFF_W  signed coefficient.
- in_sop  in  1  first coefficient of a slice.
- in_eop  in  1  last coefficient of a slice.
- out_valid  out  1  codeword beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_code  out  CODE_W  codeword, right-aligned; bit 0 is the sign bit; sent MSB-first.
- out_len  out  LEN_W  number of valid bits in out_code (0 allowed).
- out_sop, out_eop  out  1  slice flags, aligned with the beat.
- slice_bits  out  32  bits emitted in the last completed slice (only with AC_LEVEL_STATS_EN).

## Operation
- Accept on in_valid && in_ready.
- Stage 1: sign = coeff<0; abs computed at COEFF_W+1 bits (most-negative is legal); val = abs-1. Codebook cb = LEV_TO_CB[min(prev,9)]; prev = previous non-zero abs level in the slice.
- prev resets to 1 on reset and for any beat with in_sop (that beat uses prev=1). Updated to min(abs,9) only by accepted non-zero beats.
- cb fields: switch = cb[1:0], exp_k = cb[4:2], rice_k = cb[7:5]. LEV_TO_CB = {0x04,0x0A,0x05,0x06,0x04,0x28,0x28,0x28,0x28,0x4C}.
- Rice path, taken when val < (switch+1)<<rice_k:
  - q = val>>rice_k.
  - Code = q zeros, '1', then the low rice_k bits of val.
- Exp path, otherwise:
  - t = val − ((switch+1)<<rice_k) + (1<<exp_k); e = floor(log2 t).
  - Code = (e−exp_k+switch) zeros, then t in e+1 bits.
- Final code = {code, sign}; out_len = code length + 1.
- Zero coefficient: no beat, prev unchanged. Exception: a zero carrying sop or eop emits a beat with out_len=0, out_code=0 and the flags, so the packer always sees slice boundaries.
- sop and eop on the same beat are legal; both are propagated.

## Timing
- 3-stage pipeline: select → exponent/path → assemble. Latency is 3 cycles from acceptance to out_valid when unstalled; throughput 1 beat/cycle.
- Stall: advance = !out_valid || out_ready; in_ready = advance. When stalled, all stages hold.
- out_* hold stable while out_valid && !out_ready.
- Reset values: out_valid=0, out_code=0, out_len=0, out_sop=0, out_eop=0, slice_bits=0, prev=1, all stage valids=0.
- Asynchronous reset mid-slice discards in-flight beats. No partial beat is emitted after release.
- in_ready may depend combinationally on out_ready; no other combinational in→out paths.

## Configuration
- AC_LEVEL_STATS_EN defined: accumulator sums out_len of every beat leaving the block.
  - Loaded (not added) on a beat with out_sop.
  - Copied to slice_bits on the out_eop beat.
  - 32-bit, saturating.
- Not defined: slice_bits port is absent, no accumulator logic.

## Structure
- Package entropy_vlc_pkg holds:
  - LEV_TO_CB table.
  - cb field-extract functions.
  - The CODE_W ≥ 2*COEFF_W+2 check macro.
  - Shared with the DC and run coders.
- Sub-module entropy_vlc_codeword: stages 2–3. Inputs are val, cb, sign, valid and flags; it carries the hold/advance enable. It is reused by the run coder with a different table.

## Test plan
- sop, coeff +1 → cb 0x0A, code 0b10, len 2.
- Next coeff −5 (prev=1) → exp path, code 0b001011, len 6.
- Next coeff +2 (prev=5, cb 0x28) → code 0b110, len 3.
- Coeff 524287, then −524288, both with prev≥9, COEFF_W=20 → len 37 each. The sign bit is 0 then 1; no overflow.
- Zeros mid-slice produce no beats and leave prev unchanged. A zero with in_eop → one beat, len 0, out_eop=1.
- Random out_ready at 30% duty with a 200-coefficient stream → output sequence identical to the unstalled run; out_* stable while stalled. Reset asserted mid-stream → out_valid=0 immediately, and the first beat after the next sop uses prev=1.
